// File: rtl/exibe_sequencia.sv
// exibe_sequencia: reads the sequence ROM from address 0 up to a latched
// limit and shows each entry on the LEDs for a lit period followed by a
// dark gap. Pulses pronto once the last entry has been shown.
module exibe_sequencia #(
    parameter int TEMPO_ACESO   = 1000,
    parameter int TEMPO_APAGADO = 500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] rom_dado,
    output logic [3:0] rom_endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TEMPO_MAX = (TEMPO_ACESO > TEMPO_APAGADO) ? TEMPO_ACESO : TEMPO_APAGADO;
    // A 1-bit timer is kept when both periods are a single cycle
    localparam int TW = (TEMPO_MAX > 1) ? $clog2(TEMPO_MAX) : 1;

    localparam logic [TW-1:0] ULTIMO_ACESO   = TW'(TEMPO_ACESO - 1);
    localparam logic [TW-1:0] ULTIMO_APAGADO = TW'(TEMPO_APAGADO - 1);

    localparam logic [3:0] INICIAL = 4'd0;
    localparam logic [3:0] PREPARA = 4'd1;
    localparam logic [3:0] CARREGA = 4'd2;
    localparam logic [3:0] ACESO   = 4'd3;
    localparam logic [3:0] APAGADO = 4'd4;
    localparam logic [3:0] PROXIMO = 4'd5;
    localparam logic [3:0] FIM     = 4'd6;

    logic [3:0]    estado;
    logic [3:0]    proximo_estado;
    logic [TW-1:0] timer;
    logic [3:0]    limite_reg;

    // Next-state decode; unused codes fall back to INICIAL
    always_comb begin
        proximo_estado = INICIAL;
        case (estado)
            INICIAL: proximo_estado = iniciar ? PREPARA : INICIAL;
            PREPARA: proximo_estado = CARREGA;
            CARREGA: proximo_estado = ACESO;
            ACESO:   proximo_estado = (timer == ULTIMO_ACESO) ? APAGADO : ACESO;
            APAGADO: proximo_estado = (timer == ULTIMO_APAGADO) ? PROXIMO : APAGADO;
            PROXIMO: proximo_estado = (rom_endereco == limite_reg) ? FIM : PREPARA;
            FIM:     proximo_estado = INICIAL;
            default: proximo_estado = INICIAL;
        endcase
    end

    // State register and dwell timer, zeroed whenever the state changes
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
            timer  <= '0;
        end else begin
            estado <= proximo_estado;
            if (proximo_estado != estado)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end

    // Address, latched limit and LED registers
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_endereco <= '0;
            leds         <= '0;
            limite_reg   <= '0;
        end else begin
            case (estado)
                INICIAL: begin
                    leds <= '0;
                    if (iniciar) begin
                        limite_reg   <= limite;
                        rom_endereco <= '0;
                    end
                end
                CARREGA: leds <= rom_dado;
                ACESO: begin
                    if (proximo_estado != ACESO)
                        leds <= '0;
                end
                PROXIMO: begin
                    if (rom_endereco != limite_reg)
                        rom_endereco <= rom_endereco + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Status decoded from the registered state
    always_comb begin
        ocupado   = (estado != INICIAL);
        pronto    = (estado == FIM);
        db_estado = estado;
    end

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia with TEMPO_ACESO=4, TEMPO_APAGADO=2 (P=9).
module tb_exibe_sequencia;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] limite = 4'd0;
    logic [3:0] rom_dado = 4'd0;
    logic [3:0] rom_endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] rom_tab [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h3, 4'h5, 4'h6,
                                 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};

    exibe_sequencia #(.TEMPO_ACESO(4), .TEMPO_APAGADO(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .limite       (limite),
        .rom_dado     (rom_dado),
        .rom_endereco (rom_endereco),
        .leds         (leds),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // Synchronous ROM: data one cycle after the address
    always @(posedge clock) rom_dado <= rom_tab[rom_endereco];

    task automatic check(input string tag, input int cyc, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Runs one scenario; cycle c is the period after edge c-1, edge 0 samples iniciar
    task automatic run(input int lim, input int ncyc, input int pulse_at,
                       input int new_lim_at, input int reset_at, input bit hold);
        int runlen;
        int r, e, o;
        logic [3:0] x_addr, x_leds, x_db;
        logic       x_ocup, x_pronto;
        runlen = (lim + 1) * 9 + 2;
        limite  = 4'(lim);
        iniciar = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clock);
            if (!hold) iniciar = 1'b0;
            if (reset_at > 0 && c > reset_at) begin
                x_addr = 4'd0; x_leds = 4'd0; x_db = 4'd0; x_ocup = 1'b0; x_pronto = 1'b0;
            end else begin
                r = hold ? ((c - 1) % runlen) + 1 : c;
                if (r <= (lim + 1) * 9) begin
                    e = (r - 1) / 9;
                    o = (r - 1) % 9;
                    x_addr   = 4'(e);
                    x_leds   = (o >= 2 && o <= 5) ? rom_tab[e] : 4'd0;
                    x_db     = (o == 0) ? 4'd1 : (o == 1) ? 4'd2 : (o <= 5) ? 4'd3 :
                               (o <= 7) ? 4'd4 : 4'd5;
                    x_ocup   = 1'b1;
                    x_pronto = 1'b0;
                end else if (r == (lim + 1) * 9 + 1) begin
                    x_addr = 4'(lim); x_leds = 4'd0; x_db = 4'd6; x_ocup = 1'b1; x_pronto = 1'b1;
                end else begin
                    x_addr = 4'(lim); x_leds = 4'd0; x_db = 4'd0; x_ocup = 1'b0; x_pronto = 1'b0;
                end
            end
            check("leds", c, leds, x_leds);
            check("rom_endereco", c, rom_endereco, x_addr);
            check("db_estado", c, db_estado, x_db);
            check("ocupado", c, {3'b0, ocupado}, {3'b0, x_ocup});
            check("pronto", c, {3'b0, pronto}, {3'b0, x_pronto});
            reset = (c == reset_at);
            if (c == pulse_at) iniciar = 1'b1;
            if (c == new_lim_at) limite = 4'd0;
        end
        iniciar = 1'b0;
        reset   = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock);
        check("reset_leds", 0, leds, 4'd0);
        check("reset_addr", 0, rom_endereco, 4'd0);
        check("reset_db", 0, db_estado, 4'd0);
        check("reset_ocupado", 0, {3'b0, ocupado}, 4'd0);
        check("reset_pronto", 0, {3'b0, pronto}, 4'd0);
        reset = 1'b0;
        @(negedge clock);

        run(0, 12, -1, -1, -1, 1'b0);    // single entry, pronto in cycle 10
        run(2, 30, -1, -1, -1, 1'b0);    // three entries, pronto in cycle 28
        run(15, 147, -1, -1, -1, 1'b0);  // all 16 entries, no wrap, pronto in cycle 145
        run(2, 30, 13, 5, -1, 1'b0);     // iniciar re-pulsed in ACESO, limite changed mid-run
        run(2, 35, -1, -1, 14, 1'b0);    // reset during the 0010 display
        run(0, 25, -1, -1, -1, 1'b1);    // iniciar held high: back-to-back runs

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the bench can never hang
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
